// File: rtl/spi_csr_bank_if.sv
// SPI pin bundle between the synchronised pad logic and the CSR bank.
interface spi_csr_bank_if;
   logic spi_cs;
   logic spi_sck;
   logic spi_mosi;
   logic spi_miso;

   modport slave  (input spi_cs, spi_sck, spi_mosi, output spi_miso);
   modport master (output spi_cs, spi_sck, spi_mosi, input spi_miso);
endinterface

// File: rtl/spi_csr_bank.sv
// SPI mode-3 slave CSR bank: NUM_REGS RW bytes with write strobes, STAT_REGS
// read-only status bytes, burst access with auto-increment.
//
// state | meaning
// ------+-------------------------------------------------------------
// CMD   | receiving command byte {rw, addr}
// WR    | each received byte writes register[addr]; addr advances
// RD    | tx carries rdata(addr); each byte advances addr and reloads tx
module spi_csr_bank #(
   parameter int                    ADDR_W    = 7,
   parameter int                    NUM_REGS  = 64,
   parameter int                    STAT_REGS = 4,
   parameter logic [NUM_REGS*8-1:0] RESET_VAL = '0,
   parameter logic [NUM_REGS-1:0]   HOLD_MASK = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   spi_csr_bank_if.slave            spi,
   output logic [NUM_REGS*8-1:0]    csr_regs,
   output logic [NUM_REGS-1:0]      csr_wstb,
   input  logic [STAT_REGS*8-1:0]   stat_in,
   output logic                     txn_active
);

   typedef enum logic [1:0] {S_CMD, S_WR, S_RD} state_t;

   state_t                 state_q, state_d;
   logic                   sck_q;
   logic                   rise, fall, byte_done;
   logic [2:0]             bit_cnt_q;
   logic [6:0]             rx_q;
   logic [7:0]             rx_byte;
   logic [7:0]             tx_q;
   logic [7:0]             rdata;
   logic                   miso_q;
   logic                   load_q;
   logic [ADDR_W-1:0]      addr_q;
   logic [NUM_REGS*8-1:0]  regs_q;
   logic [NUM_REGS-1:0]    wstb_q;
   logic [NUM_REGS-1:0]    wr_hit;
   logic                   hold;
   logic                   cmd_done, wr_en, rd_adv;

   assign rise      = spi.spi_sck & ~sck_q;
   assign fall      = ~spi.spi_sck & sck_q;
   assign byte_done = rise & ~spi.spi_cs & (bit_cnt_q == 3'd7);
   assign rx_byte   = {rx_q, spi.spi_mosi};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_CMD;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (spi.spi_cs)
         state_d = S_CMD;
      else if (byte_done && state_q == S_CMD)
         state_d = rx_byte[7] ? S_RD : S_WR;
   end

   always_comb begin
      txn_active = (state_q != S_CMD) && !spi.spi_cs;
      cmd_done   = byte_done && (state_q == S_CMD);
      wr_en      = byte_done && (state_q == S_WR);
      rd_adv     = byte_done && (state_q == S_RD);
   end

   // Address decode; addresses outside both regions leave rdata at 0 and hit nothing.
   always_comb begin
      wr_hit = '0;
      hold   = 1'b0;
      rdata  = 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr_q == ADDR_W'(i)) begin
            wr_hit[i] = wr_en;
            hold      = HOLD_MASK[i];
            rdata     = regs_q[i*8 +: 8];
         end
      end
      for (int j = 0; j < STAT_REGS; j++) begin
         if (addr_q == ADDR_W'(NUM_REGS + j))
            rdata = stat_in[j*8 +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q <= RESET_VAL;
         wstb_q <= '0;
      end else begin
         wstb_q <= wr_hit;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_hit[i]) regs_q[i*8 +: 8] <= rx_byte;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_q     <= 1'b1;
         bit_cnt_q <= 3'd0;
         rx_q      <= '0;
         tx_q      <= 8'hFF;
         miso_q    <= 1'b1;
         load_q    <= 1'b0;
         addr_q    <= '0;
      end else begin
         sck_q <= spi.spi_sck;
         if (spi.spi_cs) begin
            bit_cnt_q <= 3'd0;
            tx_q      <= 8'hFF;
            miso_q    <= 1'b1;
            load_q    <= 1'b0;
         end else begin
            load_q <= (cmd_done & rx_byte[7]) | rd_adv;
            if (rise) begin
               bit_cnt_q <= bit_cnt_q + 3'd1;
               rx_q      <= rx_byte[6:0];
            end
            if (cmd_done)
               addr_q <= rx_byte[ADDR_W-1:0];
            else if (rd_adv || (wr_en && !hold))
               addr_q <= addr_q + 1'b1;
            // Read data lands one clk after the address settles, long before the next SCK fall.
            if (load_q)
               tx_q <= rdata;
            else if ((cmd_done && !rx_byte[7]) || wr_en)
               tx_q <= 8'hFF;
            else if (fall) begin
               miso_q <= tx_q[7];
               tx_q   <= {tx_q[6:0], 1'b0};
            end
         end
      end
   end

   assign csr_regs     = regs_q;
   assign csr_wstb     = wstb_q;
   assign spi.spi_miso = miso_q;

endmodule

// File: doc/spi_csr_bank.md
Name: spi_csr_bank

Overview:
- Parametrised SPI-slave control/status register bank; successor to the fixed-map display CSR block.
- Holds NUM_REGS generic 8-bit RW registers, exposed as a flat bus with per-register write strobes, plus STAT_REGS read-only status bytes.
- Adds an explicit read/write command bit, burst reads with auto-increment, and readback of every RW register.
- Sits between the clk-synchronised SPI pins and the display pipeline, which decodes fields from the flat bus.

Parameters:
- ADDR_W, 7: address width; command byte is {rw, addr[ADDR_W-1:0]}; fixed at 7 for a single command byte.
- NUM_REGS, 64: number of RW registers at addresses 0..NUM_REGS-1.
- STAT_REGS, 4: number of read-only status bytes at addresses NUM_REGS..NUM_REGS+STAT_REGS-1; NUM_REGS+STAT_REGS must be ≤ 2^ADDR_W.
- RESET_VAL, 0: NUM_REGS*8-bit reset image; byte i = register i.
- HOLD_MASK, 0: NUM_REGS-bit mask; a set bit marks a FIFO/command-port register whose writes do not advance the address.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- spi_cs  in  1  chip select, active-low, already synced to clk
- spi_sck  in  1  SPI clock, mode 3, already synced to clk
- spi_mosi  in  1  SPI data in, already synced to clk
- spi_miso  out  1  SPI data out
- csr_regs  out  NUM_REGS*8  flat register image; byte i = register i
- csr_wstb  out  NUM_REGS  one-clk pulse per register written
- stat_in  in  STAT_REGS*8  status bytes; byte j is read at address NUM_REGS+j
- txn_active  out  1  high while a transaction is past its command byte

Behaviour:
- Reset state:
  - csr_regs = RESET_VAL; csr_wstb = 0; spi_miso = 1; txn_active = 0.
  - FSM in CMD; bit counter = 0; tx shifter = 8'hFF.
  - Reset is asynchronous; asserting it mid-transaction aborts with no write.
- Edge detection: SCK rising/falling edges are detected from a registered copy of spi_sck.
  - Rising edge: shift spi_mosi into rx (MSB first).
  - Falling edge: spi_miso <= tx[7], then tx shifts left with 0 fill.
- Timing requirement: SCK high and low phases are each ≥ 4 clk cycles.
- CS high (any time): FSM -> CMD, bit counter cleared, tx = 8'hFF, spi_miso = 1, txn_active = 0.
  - A partially received byte is discarded; no write and no strobe occur.
- FSM states:
  - CMD:
    - On the 8th rising edge, latch rw = bit7 and addr = bits[6:0].
    - Go to RD if rw = 1, else WR; txn_active <= 1.
    - If RD, load tx with rdata(addr) within 2 clk of that edge, before the next falling edge.
  - WR, on each 8th rising edge:
    - If addr < NUM_REGS: register[addr] <= byte; csr_wstb[addr] pulses for exactly 1 clk, 1 clk after the edge.
    - Otherwise the write is ignored and no strobe is issued.
    - addr increments (mod 2^ADDR_W) unless addr < NUM_REGS and HOLD_MASK[addr] = 1.
    - spi_miso shifts 1s throughout WR.
  - RD, on each 8th rising edge: addr increments (mod 2^ADDR_W), then tx loads rdata(new addr) within 2 clk.
    - HOLD_MASK is ignored on reads.
- rdata(a):
  - a < NUM_REGS: register[a].
  - NUM_REGS ≤ a < NUM_REGS+STAT_REGS: stat_in byte (a - NUM_REGS), sampled at load time.
  - Otherwise: 8'h00.
- Held-address writes: repeated data bytes each rewrite the same register with one strobe per byte.
- Wrap-around: address 2^ADDR_W-1 increments to 0.
- At most one write per byte; csr_wstb is one-hot or zero.

Test Plan:
- After reset, no SPI activity -> csr_regs == RESET_VAL, csr_wstb == 0, spi_miso == 1.
- Write burst: CS low, bytes 0x05,0xA1,0xB2,0xC3 -> regs 5/6/7 = A1/B2/C3; csr_wstb bits 5, 6, 7 each pulse exactly once, in order.
- HOLD_MASK[10] = 1, write burst 0x0A,0x11,0x22,0x33 -> reg10 = 0x33, three strobes on bit 10, reg11 unchanged.
- Read burst from NUM_REGS-1 with stat_in byte0 = 0x5A -> MISO returns reg63, then 0x5A, then stat byte1; past the status region returns 0x00.
- CS raised after 4 data bits of a write, and rst asserted mid-byte in a second transaction -> no register change, no strobe; the next transaction decodes from CMD correctly.
- Write burst starting at address 0x7F -> 0x7F ignored with no strobe; next byte writes reg0 (wrap).
